// File: rtl/multicycle_ctrl.sv
// Multi-cycle rv32i control sequencer sharing one memory port between fetch and load/store.
// Optional retired-instruction counter is built only when RV32I_INSTRET_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  input  logic                 mem_rsp_valid,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 retire,
  output logic                 halted,
  output logic [3:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH_REQ, S_FETCH_WAIT, S_DECODE, S_EXECUTE,
    S_MEM_REQ, S_MEM_WAIT, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } cls_t;

  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam int TO_LIM = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_t          state, state_nxt;
  cls_t            cls, cls_nxt;
  logic [3:0]      cause, cause_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  function automatic cls_t decode_class(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = C_OP;
      7'b0010011: c = C_OPIMM;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state <= S_FETCH_REQ;
      cls   <= C_OP;
      cause <= 4'd0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      cause <= cause_nxt;
    end
  end

  // Counts consecutive response-less WAIT cycles; any other cycle clears it.
  always_ff @(posedge clk) begin
    if (!areset_n)
      to_cnt <= '0;
    else if ((state == S_FETCH_WAIT || state == S_MEM_WAIT) && !mem_rsp_valid)
      to_cnt <= to_cnt + TO_W'(1);
    else
      to_cnt <= '0;
  end

  // A response arriving in the limit cycle is checked first, so it beats the trap.
  assign to_expire = TO_EN && (to_cnt == TO_W'(TO_LIM));

  always_comb begin
    state_nxt     = state;
    cls_nxt       = cls;
    cause_nxt     = cause;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 2'd0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = 2'd0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (mem_rsp_valid) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (to_expire) begin
          cause_nxt = 4'd1;
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        cls_nxt = decode_class(opcode);
        if (cls_nxt == C_ILLEGAL) begin
          cause_nxt = 4'd2;
          state_nxt = S_TRAP;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls)
          C_OP:    alu_op = 2'd1;
          C_OPIMM: begin alu_src_b = 1'b1; alu_op = 2'd1; end
          C_LUI:   begin alu_src_b = 1'b1; alu_op = 2'd3; end
          C_AUIPC, C_JAL: begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
          C_BRANCH: alu_op = 2'd2;
          default: alu_src_b = 1'b1;
        endcase
        if (cls == C_BRANCH) begin
          pc_we     = 1'b1;
          pc_src    = branch_taken ? 2'd1 : 2'd0;
          retire    = 1'b1;
          state_nxt = S_FETCH_REQ;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_nxt = S_MEM_REQ;
        end else begin
          state_nxt = S_WRITEBACK;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr_sel  = 1'b1;
        mem_we        = (cls == C_STORE);
        if (mem_req_ready) state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          if (cls == C_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH_REQ;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WRITEBACK;
          end
        end else if (to_expire) begin
          cause_nxt = (cls == C_STORE) ? 4'd7 : 4'd5;
          state_nxt = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (cls)
          C_LOAD: wb_sel = 2'd1;
          C_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          C_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default: ;
        endcase
        state_nxt = S_FETCH_REQ;
      end
      S_TRAP: halted = 1'b1;
      default: state_nxt = S_FETCH_REQ;
    endcase
  end

  assign trap_cause = cause;

`ifdef RV32I_INSTRET_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!areset_n)
      cnt <= '0;
    else if (retire)
      cnt <= cnt + CNT_WIDTH'(1);
  end

  assign instret = cnt;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push expected
// output snapshots; a negedge monitor pops one whenever the controller shows activity.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        areset_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_addr_sel, mem_rsp_valid;
  logic        ir_we, mdr_we, pc_we, rf_we, alu_src_a, alu_src_b, retire, halted;
  logic [1:0]  pc_src, wb_sel, alu_op;
  logic [3:0]  trap_cause;
  logic [63:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(64)) dut (
    .clk(clk), .areset_n(areset_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .mem_rsp_valid(mem_rsp_valid), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_ADD = 7'b0110011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;

  typedef struct packed {
    logic mreq, mwe, msel, irwe, mdrwe, pcwe;
    logic [1:0] pcsrc;
    logic rfwe;
    logic [1:0] wbsel;
    logic ret, hlt;
    logic [3:0] cause;
    logic [63:0] cnt;
  } out_t;

  typedef struct packed {
    out_t o;
    logic care;
    logic [3:0] alu;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [63:0] exp_cnt = '0;
  out_t        mon_o;
  exp_t        mon_x;
  logic [3:0]  mon_alu;

  always @(negedge clk) begin
    if (mon_en && (mem_req_valid || ir_we || mdr_we || pc_we || rf_we || retire || halted)) begin
      mon_o = '{mreq: mem_req_valid, mwe: mem_we, msel: mem_addr_sel, irwe: ir_we,
                mdrwe: mdr_we, pcwe: pc_we, pcsrc: pc_src, rfwe: rf_we, wbsel: wb_sel,
                ret: retire, hlt: halted, cause: trap_cause, cnt: instret};
      mon_alu = {alu_src_a, alu_src_b, alu_op};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activity @%0t: actual=%h required=none", $time, mon_o);
      end else begin
        mon_x = q.pop_front();
        if (mon_o !== mon_x.o || (mon_x.care && mon_alu !== mon_x.alu)) begin
          errors++;
          $display("FAIL outputs @%0t: actual=%h alu=%h required=%h alu=%h",
                   $time, mon_o, mon_alu, mon_x.o, mon_x.alu);
        end
      end
    end
  end

  function automatic exp_t e_base();
    exp_t e;
    e = '0;
    e.o.cnt = exp_cnt;
    return e;
  endfunction

  function automatic exp_t x_fr();
    exp_t e;
    e = e_base();
    e.o.mreq = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_trap(input logic [3:0] c);
    exp_t e;
    e = e_base();
    e.o.hlt = 1'b1;
    e.o.cause = c;
    return e;
  endfunction

  task automatic cyc(input logic rst_n, input logic rdy, input logic rsp, input logic br,
                     input logic push, input exp_t e);
    areset_n = rst_n;
    mem_req_ready = rdy;
    mem_rsp_valid = rsp;
    branch_taken = br;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
`ifdef RV32I_INSTRET_CNT_EN
    exp_cnt = exp_cnt + 64'd1;
`endif
  endtask

  task automatic fetch(input logic [6:0] op);
    exp_t e;
    opcode = op;
    cyc(1, 1, 0, 0, 1, x_fr());
    e = e_base(); e.o.irwe = 1'b1;
    cyc(1, 0, 1, 0, 1, e);
    cyc(1, 0, 0, 0, 0, '0);
  endtask

  task automatic do_wb(input logic [6:0] op, input logic [1:0] ws, input logic [1:0] ps);
    exp_t e;
    fetch(op);
    cyc(1, 0, 1, 0, 0, '0);
    e = e_base(); e.o.rfwe = 1'b1; e.o.wbsel = ws; e.o.pcwe = 1'b1; e.o.pcsrc = ps; e.o.ret = 1'b1;
    cyc(1, 0, 0, 0, 1, e);
    bump();
  endtask

  task automatic do_branch(input logic br);
    exp_t e;
    fetch(OP_BEQ);
    e = e_base(); e.o.pcwe = 1'b1; e.o.pcsrc = {1'b0, br}; e.o.ret = 1'b1;
    e.care = 1'b1; e.alu = 4'b0010;
    cyc(1, 0, 0, br, 1, e);
    bump();
  endtask

  task automatic do_store();
    exp_t e;
    fetch(OP_SW);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.mreq = 1'b1; e.o.msel = 1'b1; e.o.mwe = 1'b1;
    cyc(1, 1, 0, 0, 1, e);
    e = e_base(); e.o.pcwe = 1'b1; e.o.ret = 1'b1;
    cyc(1, 0, 1, 0, 1, e);
    bump();
  endtask

  task automatic do_load_stall();
    exp_t e;
    fetch(OP_LW);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.mreq = 1'b1; e.o.msel = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, e);
    cyc(1, 1, 0, 0, 1, e);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.mdrwe = 1'b1;
    cyc(1, 0, 1, 0, 1, e);
    e = e_base(); e.o.rfwe = 1'b1; e.o.wbsel = 2'd1; e.o.pcwe = 1'b1; e.o.ret = 1'b1;
    cyc(1, 0, 0, 0, 1, e);
    bump();
  endtask

  task automatic mem_timeout(input logic [6:0] op, input logic [3:0] c);
    exp_t e;
    fetch(op);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.mreq = 1'b1; e.o.msel = 1'b1; e.o.mwe = (op == OP_SW);
    cyc(1, 1, 0, 0, 1, e);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, 1, x_trap(c));
    cyc(0, 0, 0, 0, 1, x_trap(c));
    exp_cnt = '0;
  endtask

  initial begin
    exp_t e;
    areset_n = 1'b0; opcode = OP_ADDI; branch_taken = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // reset holds FETCH_REQ with counters and cause cleared
    cyc(0, 0, 1, 0, 1, x_fr());
    cyc(0, 1, 0, 0, 1, x_fr());

    do_wb(OP_ADDI, 2'd0, 2'd0);
    do_load_stall();
    do_branch(1'b1);
    do_branch(1'b0);
    do_wb(OP_JALR, 2'd2, 2'd2);
    do_wb(OP_JAL, 2'd2, 2'd1);
    do_wb(OP_LUI, 2'd0, 2'd0);
    do_wb(OP_AUIPC, 2'd0, 2'd0);
    do_wb(OP_ADD, 2'd0, 2'd0);
    do_store();

    // illegal SYSTEM opcode halts; memory activity is ignored until reset
    fetch(OP_SYS);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 1, x_trap(4'd2));
    cyc(0, 0, 0, 0, 1, x_trap(4'd2));
    exp_cnt = '0;

    // fetch timeout after 4 silent FETCH_WAIT cycles
    cyc(1, 1, 0, 0, 1, x_fr());
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, 1, x_trap(4'd1));
    cyc(1, 0, 0, 0, 1, x_trap(4'd1));
    cyc(0, 0, 0, 0, 1, x_trap(4'd1));
    exp_cnt = '0;

    // response in the limit cycle wins over the timeout
    opcode = OP_ADDI;
    cyc(1, 1, 0, 0, 1, x_fr());
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.irwe = 1'b1;
    cyc(1, 0, 1, 0, 1, e);
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.rfwe = 1'b1; e.o.pcwe = 1'b1; e.o.ret = 1'b1;
    cyc(1, 0, 0, 0, 1, e);
    bump();

    mem_timeout(OP_LW, 4'd5);
    mem_timeout(OP_SW, 4'd7);

    // reset during MEM_WAIT of a store aborts it; the late response is ignored
    do_wb(OP_ADDI, 2'd0, 2'd0);
    fetch(OP_SW);
    cyc(1, 0, 0, 0, 0, '0);
    e = e_base(); e.o.mreq = 1'b1; e.o.msel = 1'b1; e.o.mwe = 1'b1;
    cyc(1, 1, 0, 0, 1, e);
    cyc(0, 0, 0, 0, 0, '0);
    exp_cnt = '0;
    cyc(1, 0, 1, 0, 1, x_fr());
    do_wb(OP_ADDI, 2'd0, 2'd0);
    do_branch(1'b1);

    mon_en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
